axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the core's single AXI read channel between the instruction-fetch port and the data-load port.
- Both requesters use the sram-like protocol (req / addr_ok / data_ok).
- Fixed priority goes to data, with one outstanding transaction at a time.
- Handles fetch-stage flush by draining and discarding an in-flight instruction response.

Parameters:
INST_ID, 4'd0, ARID used for instruction reads
DATA_ID, 4'd1, ARID used for data reads

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  fetch-stage flush; cancels instruction-side transaction
inst_req  in  1  instruction read request
inst_addr  in  32  instruction address (word)
inst_addr_ok  out  1  instruction request accepted (AR handshake)
inst_data_ok  out  1  instruction read data valid
inst_rdata  out  32  instruction read data
data_req  in  1  data read request
data_addr  in  32  data address
data_size  in  2  0=byte, 1=half, 2=word
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data read data valid
data_rdata  out  32  data read data
data_rerr  out  1  rresp != OKAY, valid with data_data_ok
arid  out  4  read ID
araddr  out  32  read address
arlen  out  8  constant 0 (single beat)
arsize  out  3  {1'b0, size}
arvalid  out  1  address valid
arready  in  1  address ready
rid  in  4  response ID (ignored for routing; owner register used)
rdata  in  32  response data
rresp  in  2  response status
rlast  in  1  last beat
rvalid  in  1  response valid
rready  out  1  response ready

Behaviour:
- Reset is asynchronous and active-high.
  - Reset returns to IDLE and clears owner, cancel, arvalid and rready immediately, including mid-transaction.
  - All *_ok outputs are 0 during reset.
  - araddr, arid and arsize reset to 0.
- FSM states: IDLE, ADDR, RESP.
- IDLE:
  - If data_req=1: latch data_addr and data_size, owner=DATA, go to ADDR.
  - Else if inst_req=1 and flush=0: latch inst_addr with size=2, owner=INST, go to ADDR.
  - Data wins when both requests arrive in the same cycle.
  - A request is seen no earlier than the cycle after the previous transaction ends.
- ADDR:
  - arvalid=1; araddr, arid and arsize are stable from the latched registers.
  - On arvalid&arready: pulse the owner's *_addr_ok for exactly that cycle (combinational from arready), then go to RESP.
  - arvalid is never dropped before the handshake, even if flush occurs.
- RESP:
  - rready=1.
  - On rvalid&rlast: pulse the owner's *_data_ok in the same cycle, *_rdata=rdata (combinational pass-through), then go to IDLE.
  - data_rerr = (rresp!=0) on the data_data_ok cycle.
- Response latency: data_ok occurs ≥2 cycles after the request is first sampled in IDLE (minimum IDLE->ADDR->RESP).
- Flush:
  - flush=1 while owner=INST in ADDR or RESP sets the cancel flag.
  - While cancel=1: inst_addr_ok still pulses at the AR handshake so the fetch stage retires the request; the response is consumed (rready=1) but inst_data_ok stays 0.
  - cancel clears on return to IDLE.
  - flush in IDLE only blocks a same-cycle inst grant.
  - flush does not affect a data transaction.
- Simultaneous flush and rvalid&rlast in RESP for INST: the response is dropped (inst_data_ok=0).
- Starvation: inst may wait indefinitely under continuous data_req; this is acceptable because the pipeline stalls fetch while a load is outstanding.
- Non-owner *_addr_ok, *_data_ok and *_rdata are 0.
- Writes are out of scope (separate write channel).

Test Plan:
1. Reset mid-flight: rst=1 in RESP -> arvalid=0, rready=0 and FSM=IDLE immediately; a later rvalid causes no data_ok.
2. Single inst read: inst_req=1, inst_addr=0xbfc00000, arready=1, rvalid/rlast one cycle later with rdata=0x3c1d8000 -> araddr=0xbfc00000, arid=0, arsize=2, arlen=0; inst_addr_ok pulses 1 cycle; inst_data_ok pulses 1 cycle with inst_rdata=0x3c1d8000.
3. Simultaneous requests: inst_req=1 and data_req=1 (data_addr=0x80001004, size=0) -> data granted first (arid=1, arsize=0); inst granted in the cycle after data_data_ok; two serialized transactions.
4. arready backpressure: arready=0 for 5 cycles -> arvalid and araddr stable all 5 cycles; addr_ok only on the handshake cycle.
5. Flush during RESP: inst transaction in RESP, flush=1, then rvalid&rlast rdata=0xdeadbeef -> rready=1, inst_data_ok=0; next inst_req to 0xbfc00380 is served normally.
6. Error response: data read with rresp=2'b10 -> data_data_ok=1 and data_rerr=1 in the same cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// AXI read-channel (AR + R) bundle between the arbiter and the memory side.
// master = arbiter, slave = memory/interconnect.
interface axi_read_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between the instruction-fetch and data-load
// sram-like ports; data has fixed priority, one transaction outstanding.
module axi_read_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        data_rerr,
    axi_read_arbiter_if.master axi
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t              state, state_d;
    logic                own_data, own_data_d;
    logic                cancel, cancel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic                arvalid_c, rready_c;

    // rid is not used for routing: the owner register identifies the response
    logic unused_rid;
    assign unused_rid = ^axi.rid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            own_data <= 1'b0;
            cancel   <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
        end else begin
            state    <= state_d;
            own_data <= own_data_d;
            cancel   <= cancel_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
        end
    end

    always_comb begin
        state_d      = state;
        own_data_d   = own_data;
        cancel_d     = cancel;
        addr_d       = addr_q;
        size_d       = size_q;
        arvalid_c    = 1'b0;
        rready_c     = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        data_rerr    = 1'b0;

        case (state)
            IDLE: begin
                cancel_d = 1'b0;
                if (data_req) begin
                    addr_d     = data_addr;
                    size_d     = data_size;
                    own_data_d = 1'b1;
                    state_d    = ADDR;
                end else if (inst_req && !flush) begin
                    addr_d     = inst_addr;
                    size_d     = SIZE_W'(2);
                    own_data_d = 1'b0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                // AR stays asserted through a flush; the fetch stage still
                // needs addr_ok to retire its request
                arvalid_c = 1'b1;
                if (!own_data && flush) cancel_d = 1'b1;
                if (axi.arready) begin
                    state_d = RESP;
                    if (own_data) data_addr_ok = 1'b1;
                    else          inst_addr_ok = 1'b1;
                end
            end
            RESP: begin
                rready_c = 1'b1;
                if (!own_data && flush) cancel_d = 1'b1;
                if (axi.rvalid && axi.rlast) begin
                    state_d  = IDLE;
                    cancel_d = 1'b0;
                    if (own_data) begin
                        data_data_ok = 1'b1;
                        data_rdata   = axi.rdata;
                        data_rerr    = |axi.rresp;
                    end else if (!cancel && !flush) begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = axi.rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign axi.arvalid = arvalid_c;
    assign axi.rready  = rready_c;
    assign axi.araddr  = addr_q;
    assign axi.arid    = own_data ? DATA_ID : INST_ID;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arlen   = 8'd0;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: transaction-level model compared every
// cycle, plus literal expectations at key points of each scenario.
module tb_axi_read_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        data_rerr;

    axi_read_arbiter_if axi ();

    axi_read_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .data_rerr    (data_rerr),
        .axi          (axi.master)
    );

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: the one outstanding read and its progress
    bit          m_busy = 1'b0;
    bit          m_own_data = 1'b0;
    bit          m_ar_done = 1'b0;
    bit          m_cancelled = 1'b0;
    logic [31:0] m_addr = '0;
    logic [1:0]  m_size = '0;

    always @(negedge clk) begin
        bit e_arvalid, e_rready, finish;
        if (!done) begin
            if (rst) begin
                m_busy = 0; m_own_data = 0; m_ar_done = 0; m_cancelled = 0;
                m_addr = '0; m_size = '0;
            end
            e_arvalid = m_busy && !m_ar_done;
            e_rready  = m_busy && m_ar_done;
            finish    = e_rready && axi.rvalid && axi.rlast;

            check("arvalid", 32'(axi.arvalid), 32'(e_arvalid));
            check("rready", 32'(axi.rready), 32'(e_rready));
            check("araddr", axi.araddr, m_addr);
            check("arid", 32'(axi.arid), m_own_data ? 32'd1 : 32'd0);
            check("arsize", 32'(axi.arsize), 32'(m_size));
            check("arlen", 32'(axi.arlen), 32'd0);
            check("inst_addr_ok", 32'(inst_addr_ok), 32'(e_arvalid && axi.arready && !m_own_data));
            check("data_addr_ok", 32'(data_addr_ok), 32'(e_arvalid && axi.arready && m_own_data));
            check("inst_data_ok", 32'(inst_data_ok),
                  32'(finish && !m_own_data && !m_cancelled && !flush));
            check("inst_rdata", inst_rdata,
                  (finish && !m_own_data && !m_cancelled && !flush) ? axi.rdata : 32'd0);
            check("data_data_ok", 32'(data_data_ok), 32'(finish && m_own_data));
            check("data_rdata", data_rdata, (finish && m_own_data) ? axi.rdata : 32'd0);
            check("data_rerr", 32'(data_rerr), 32'(finish && m_own_data && axi.rresp != 2'd0));

            if (rst) begin
                // held in reset
            end else if (!m_busy) begin
                if (data_req) begin
                    m_busy = 1; m_own_data = 1; m_addr = data_addr; m_size = data_size;
                end else if (inst_req && !flush) begin
                    m_busy = 1; m_own_data = 0; m_addr = inst_addr; m_size = 2'd2;
                end
            end else if (!m_ar_done) begin
                if (!m_own_data && flush) m_cancelled = 1;
                if (axi.arready) m_ar_done = 1;
            end else if (finish) begin
                m_busy = 0; m_ar_done = 0; m_cancelled = 0;
            end else if (!m_own_data && flush) begin
                m_cancelled = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic resp(input logic v, input logic [31:0] d, input logic [1:0] r);
        axi.rvalid = v; axi.rlast = v; axi.rdata = d; axi.rresp = r;
    endtask

    initial begin
        rst = 1; flush = 0; inst_req = 0; inst_addr = '0;
        data_req = 0; data_addr = '0; data_size = '0;
        axi.arready = 0; axi.rid = '0; resp(0, '0, 2'd0);
        cyc(); cyc(); settle();
        check("rst arvalid", 32'(axi.arvalid), 32'd0);
        check("rst araddr", axi.araddr, 32'd0);
        check("rst arsize", 32'(axi.arsize), 32'd0);

        // single instruction read
        cyc(); rst = 0;
        cyc(); inst_req = 1; inst_addr = 32'hbfc00000; axi.arready = 1; settle();
        check("t2 idle arvalid", 32'(axi.arvalid), 32'd0);
        cyc(); settle();
        check("t2 addr_ok", 32'(inst_addr_ok), 32'd1);
        check("t2 araddr", axi.araddr, 32'hbfc00000);
        check("t2 arsize", 32'(axi.arsize), 32'd2);
        check("t2 arid", 32'(axi.arid), 32'd0);
        cyc(); inst_req = 0; axi.rid = 4'd1; resp(1, 32'h3c1d8000, 2'd0); settle();
        check("t2 addr_ok gone", 32'(inst_addr_ok), 32'd0);
        check("t2 data_ok", 32'(inst_data_ok), 32'd1);
        check("t2 rdata", inst_rdata, 32'h3c1d8000);
        cyc(); resp(0, '0, 2'd0); axi.rid = '0; settle();
        check("t2 data_ok gone", 32'(inst_data_ok), 32'd0);

        // simultaneous requests: data first, inst right after
        cyc(); inst_req = 1; inst_addr = 32'hbfc00004;
        data_req = 1; data_addr = 32'h80001004; data_size = 2'd0; settle();
        cyc(); settle();
        check("t3 data_addr_ok", 32'(data_addr_ok), 32'd1);
        check("t3 inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check("t3 arid", 32'(axi.arid), 32'd1);
        check("t3 arsize", 32'(axi.arsize), 32'd0);
        check("t3 araddr", axi.araddr, 32'h80001004);
        cyc(); data_req = 0; resp(1, 32'h11223344, 2'd0); settle();
        check("t3 data_data_ok", 32'(data_data_ok), 32'd1);
        check("t3 data_rdata", data_rdata, 32'h11223344);
        check("t3 inst_data_ok", 32'(inst_data_ok), 32'd0);
        cyc(); resp(0, '0, 2'd0); settle();
        check("t3 idle arvalid", 32'(axi.arvalid), 32'd0);
        cyc(); settle();
        check("t3 inst addr_ok", 32'(inst_addr_ok), 32'd1);
        check("t3 inst araddr", axi.araddr, 32'hbfc00004);
        cyc(); inst_req = 0; resp(1, 32'h0badf00d, 2'd0); settle();
        check("t3 inst data_ok", 32'(inst_data_ok), 32'd1);
        cyc(); resp(0, '0, 2'd0);

        // arready backpressure, then error response
        cyc(); data_req = 1; data_addr = 32'h80002000; data_size = 2'd2; axi.arready = 0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t4 arvalid", 32'(axi.arvalid), 32'd1);
            check("t4 araddr", axi.araddr, 32'h80002000);
            check("t4 addr_ok", 32'(data_addr_ok), 32'd0);
            cyc();
        end
        axi.arready = 1; settle();
        check("t4 handshake addr_ok", 32'(data_addr_ok), 32'd1);
        cyc(); data_req = 0; resp(1, 32'hcafef00d, 2'b10); settle();
        check("t6 data_ok", 32'(data_data_ok), 32'd1);
        check("t6 rerr", 32'(data_rerr), 32'd1);
        cyc(); resp(0, '0, 2'd0); settle();
        check("t6 idle rready", 32'(axi.rready), 32'd0);

        // flush during RESP drops the response, next fetch is normal
        cyc(); inst_req = 1; inst_addr = 32'hbfc00100;
        cyc(); cyc(); inst_req = 0; flush = 1; settle();
        check("t5 rready", 32'(axi.rready), 32'd1);
        cyc(); flush = 0; resp(1, 32'hdeadbeef, 2'd0); settle();
        check("t5 rready resp", 32'(axi.rready), 32'd1);
        check("t5 data_ok dropped", 32'(inst_data_ok), 32'd0);
        check("t5 rdata zero", inst_rdata, 32'd0);
        cyc(); resp(0, '0, 2'd0); inst_req = 1; inst_addr = 32'hbfc00380;
        cyc(); settle();
        check("t5 next addr_ok", 32'(inst_addr_ok), 32'd1);
        check("t5 next araddr", axi.araddr, 32'hbfc00380);
        cyc(); inst_req = 0; resp(1, 32'h24020001, 2'd0); settle();
        check("t5 next data_ok", 32'(inst_data_ok), 32'd1);
        check("t5 next rdata", inst_rdata, 32'h24020001);
        cyc(); resp(0, '0, 2'd0);

        // flush during ADDR under backpressure, then flush coincident with rlast
        cyc(); inst_req = 1; inst_addr = 32'hbfc00200; axi.arready = 0;
        cyc(); flush = 1; settle();
        check("fa arvalid held", 32'(axi.arvalid), 32'd1);
        cyc(); flush = 0; axi.arready = 1; settle();
        check("fa addr_ok", 32'(inst_addr_ok), 32'd1);
        cyc(); inst_req = 0; resp(1, 32'h00000055, 2'd0); settle();
        check("fa data_ok dropped", 32'(inst_data_ok), 32'd0);
        cyc(); resp(0, '0, 2'd0); inst_req = 1; inst_addr = 32'hbfc00300;
        cyc(); cyc(); inst_req = 0; flush = 1; resp(1, 32'h00000066, 2'd0); settle();
        check("fr same-cycle drop", 32'(inst_data_ok), 32'd0);
        cyc(); flush = 0; resp(0, '0, 2'd0);

        // flush in IDLE blocks the inst grant only for that cycle
        cyc(); inst_req = 1; inst_addr = 32'hbfc00400; flush = 1;
        cyc(); flush = 0; settle();
        check("fi blocked", 32'(axi.arvalid), 32'd0);
        cyc(); settle();
        check("fi granted", 32'(inst_addr_ok), 32'd1);
        cyc(); inst_req = 0; resp(1, 32'h77, 2'd0);
        cyc(); resp(0, '0, 2'd0);

        // flush has no effect on a data transaction
        cyc(); data_req = 1; data_addr = 32'h80004000; data_size = 2'd1; flush = 1;
        cyc(); settle();
        check("fd arsize", 32'(axi.arsize), 32'd1);
        cyc(); data_req = 0; resp(1, 32'h0000beef, 2'd0); settle();
        check("fd data_ok", 32'(data_data_ok), 32'd1);
        cyc(); flush = 0; resp(0, '0, 2'd0);

        // reset mid-flight
        cyc(); data_req = 1; data_addr = 32'h80003000; data_size = 2'd2;
        cyc(); cyc(); data_req = 0; settle();
        check("t1 rready before", 32'(axi.rready), 32'd1);
        rst = 1; settle();
        check("t1 arvalid", 32'(axi.arvalid), 32'd0);
        check("t1 rready", 32'(axi.rready), 32'd0);
        check("t1 araddr", axi.araddr, 32'd0);
        cyc(); rst = 0; resp(1, 32'h12345678, 2'd0); settle();
        check("t1 late data_ok", 32'(data_data_ok), 32'd0);
        check("t1 late rready", 32'(axi.rready), 32'd0);
        cyc(); resp(0, '0, 2'd0);
        cyc(); cyc();

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
